// File: rtl/rv_imm_pkg.sv
// Shared RV32I packing definitions: format codes, opcodes, the nop word and the field bundle.
// The IMM_RANGE_CHECK_EN build option is consumed by imm_pack, not here.
package rv_imm_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned FMT_W    = 3;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned F7_W     = 7;
    localparam int unsigned IMM_W    = 32;

    typedef enum logic [FMT_W-1:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHIFT = 3'd6,
        FMT_RSVD  = 3'd7
    } fmt_e;

    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'h13;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'h23;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'h63;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'h6F;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'h37;

    localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0013;

    // Decoded fields presented to the packer
    typedef struct packed {
        fmt_e                fmt;
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs1;
        logic [REG_W-1:0]    rs2;
        logic [F3_W-1:0]     funct3;
        logic [F7_W-1:0]     funct7;
        logic [IMM_W-1:0]    imm;
    } fields_t;

endpackage

// File: rtl/imm_encoder_if.sv
// Valid/ready stream bundle between a field producer and the instruction packer.
// master drives decoded fields and consumes packed words; slave is the packer.
interface imm_encoder_if;
    import rv_imm_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [FMT_W-1:0]    in_fmt;
    logic [OPCODE_W-1:0] in_opcode;
    logic [REG_W-1:0]    in_rd;
    logic [REG_W-1:0]    in_rs1;
    logic [REG_W-1:0]    in_rs2;
    logic [F3_W-1:0]     in_funct3;
    logic [F7_W-1:0]     in_funct7;
    logic [IMM_W-1:0]    in_imm;
    logic                out_valid;
    logic                out_ready;
    logic [INST_W-1:0]   out_inst;
    logic                out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );

endinterface

// File: rtl/imm_encoder_imm_pack.sv
// Combinational packer: scatters the immediate into the format's slots and flags bad inputs.
// Define IMM_RANGE_CHECK_EN to flag immediates the format cannot represent.
module imm_pack
    import rv_imm_pkg::*;
(
    input  fields_t           f,
    output logic [INST_W-1:0] inst,
    output logic              range_err
);

    always_comb begin
        inst = NOP_WORD;
        case (f.fmt)
            FMT_R:     inst = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I:     inst = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            FMT_S:     inst = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            FMT_B:     inst = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                               f.imm[4:1], f.imm[11], f.opcode};
            FMT_U:     inst = {f.imm[31:12], f.rd, f.opcode};
            FMT_J:     inst = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            FMT_SHIFT: inst = {f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
            default:   inst = NOP_WORD;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // A field fits when every bit above it matches the sign bit it keeps
    always_comb begin
        range_err = 1'b0;
        case (f.fmt)
            FMT_I, FMT_S: range_err = !((&f.imm[31:11]) || !(|f.imm[31:11]));
            FMT_B:        range_err = !((&f.imm[31:12]) || !(|f.imm[31:12])) || f.imm[0];
            FMT_J:        range_err = !((&f.imm[31:20]) || !(|f.imm[31:20])) || f.imm[0];
            FMT_U:        range_err = |f.imm[11:0];
            FMT_SHIFT:    range_err = |f.imm[31:5];
            FMT_RSVD:     range_err = 1'b1;
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = (f.fmt == FMT_RSVD);
`endif

endmodule

// File: rtl/imm_encoder.sv
// RV32I instruction packer with one output register stage and saturating accept/error counters.
// Range checking is enabled by defining IMM_RANGE_CHECK_EN (see imm_pack).
module imm_encoder
    import rv_imm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    fields_t           fields;
    logic [INST_W-1:0] pack_inst;
    logic              pack_err;
    logic              ready_c;
    logic              fire_c;
    logic              accept_c;
    logic              valid_q;
    logic [INST_W-1:0] inst_q;
    logic              err_q;

    always_comb begin
        fields.fmt    = fmt_e'(bus.in_fmt);
        fields.opcode = bus.in_opcode;
        fields.rd     = bus.in_rd;
        fields.rs1    = bus.in_rs1;
        fields.rs2    = bus.in_rs2;
        fields.funct3 = bus.in_funct3;
        fields.funct7 = bus.in_funct7;
        fields.imm    = bus.in_imm;
    end

    imm_pack u_pack (
        .f         (fields),
        .inst      (pack_inst),
        .range_err (pack_err)
    );

    // Ready ignores in_valid so producers may wait on it without a loop
    assign ready_c  = !valid_q || bus.out_ready;
    assign fire_c   = bus.in_valid && ready_c;
    assign accept_c = valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else if (fire_c) begin
            valid_q <= 1'b1;
            inst_q  <= pack_inst;
            err_q   <= pack_err;
        end else if (accept_c) begin
            valid_q <= 1'b0;
        end
    end

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_cnt <= '0;
            err_cnt  <= '0;
        end else if (accept_c) begin
            if (inst_cnt != {CNT_W{1'b1}}) inst_cnt <= inst_cnt + CNT_W'(1);
            if (err_q && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_inst  = inst_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus a randomized stream vs. a reference model.
// Honors IMM_RANGE_CHECK_EN the same way the design does.
module tb_imm_encoder;

    localparam int unsigned TB_CNT_W = 4;
    localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [TB_CNT_W-1:0] inst_cnt;
    logic [TB_CNT_W-1:0] err_cnt;
    int                  n_tests = 0;
    int                  n_fail  = 0;

    imm_encoder_if bus ();

    imm_encoder #(.CNT_W(TB_CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .inst_cnt (inst_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // Reference: builds the word from the slot table with shifts and masks
    function automatic logic [32:0] model(input int fmt, input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] imm);
        logic [31:0] w;
        logic [31:0] rdv, rs1v, rs2v, f3v, f7v;
        logic        e;
        int          s;
        rdv  = 32'(rd) << 7;
        f3v  = 32'(f3) << 12;
        rs1v = 32'(rs1) << 15;
        rs2v = 32'(rs2) << 20;
        f7v  = 32'(f7) << 25;
        s    = $signed(imm);
        e    = 1'b0;
        w    = 32'h13;
        case (fmt)
            0: w = f7v | rs2v | rs1v | f3v | rdv | 32'(op);
            1: begin
                w = ((imm & 32'hFFF) << 20) | rs1v | f3v | rdv | 32'(op);
                e = (s < -2048) || (s > 2047);
            end
            2: begin
                w = (((imm >> 5) & 32'h7F) << 25) | rs2v | rs1v | f3v | ((imm & 32'h1F) << 7) | 32'(op);
                e = (s < -2048) || (s > 2047);
            end
            3: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | rs2v | rs1v | f3v
                    | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'(op);
                e = (s < -4096) || (s > 4095) || (imm % 2 != 0);
            end
            4: begin
                w = (imm & 32'hFFFF_F000) | rdv | 32'(op);
                e = (imm % 4096) != 0;
            end
            5: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                    | (imm & 32'h000F_F000) | rdv | 32'(op);
                e = (s < -1048576) || (s > 1048575) || (imm % 2 != 0);
            end
            6: begin
                w = f7v | ((imm & 32'h1F) << 20) | rs1v | f3v | rdv | 32'(op);
                e = imm > 31;
            end
            default: w = 32'h13;
        endcase
        if (fmt == 7) e = 1'b1;
        else if (!CHECK_EN) e = 1'b0;
        return {e, w};
    endfunction

    task automatic drive(input int fmt, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        bus.in_fmt    = 3'(fmt);
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        drive(0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        do_reset();
        n_tests++;
        if ({bus.out_valid, bus.out_err, bus.out_inst} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b e=%b i=%h want all 0", bus.out_valid, bus.out_err, bus.out_inst);
        end
        n_tests++;
        if ({inst_cnt, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", inst_cnt, err_cnt);
        end
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_i_s();
        do_reset();
        bus.out_ready = 1'b1;
        drive(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        bus.in_valid = 1'b1;
        tick();
        drive(2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        n_tests++;
        if ({bus.out_valid, bus.out_err, bus.out_inst} !== {2'b10, 32'hFFF0_0093}) begin
            n_fail++;
            $display("FAIL i_word: got v=%b e=%b i=%h want v=1 e=0 i=fff00093",
                     bus.out_valid, bus.out_err, bus.out_inst);
        end
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if ({bus.out_valid, bus.out_err, bus.out_inst} !== {2'b10, 32'h0020_A423}) begin
            n_fail++;
            $display("FAIL s_word: got v=%b e=%b i=%h want v=1 e=0 i=0020a423",
                     bus.out_valid, bus.out_err, bus.out_inst);
        end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || inst_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL is_drain: got v=%b cnt=%0d want v=0 cnt=2", bus.out_valid, inst_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.out_ready = 1'b1;
        drive(3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        bus.in_valid = 1'b1;
        tick();
        drive(5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        n_tests++;
        if (bus.out_inst !== 32'hFE00_0EE3 || bus.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b_word: got %h e=%b want fe000ee3 e=0", bus.out_inst, bus.out_err);
        end
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_inst !== 32'h0010_00EF || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL j_word: got %h v=%b want 001000ef v=1", bus.out_inst, bus.out_valid);
        end
        tick();
        n_tests++;
        if (inst_cnt !== 4'd2 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_cnt: got cnt=%0d v=%b want cnt=2 v=0", inst_cnt, bus.out_valid);
        end
    endtask

    task automatic test_range();
        do_reset();
        bus.out_ready = 1'b1;
        drive(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_inst !== 32'h8000_0093 || bus.out_err !== CHECK_EN) begin
            n_fail++;
            $display("FAIL range_word: got %h e=%b want 80000093 e=%b", bus.out_inst, bus.out_err, CHECK_EN);
        end
        tick();
        n_tests++;
        if (err_cnt !== 4'(CHECK_EN) || inst_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL range_cnt: got err=%0d inst=%0d want err=%0d inst=1", err_cnt, inst_cnt, CHECK_EN);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        drive(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        bus.in_valid = 1'b1;
        tick();
        drive(2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'hFFF0_0093 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b i=%h rdy=%b want v=1 i=fff00093 rdy=0",
                         c, bus.out_valid, bus.out_inst, bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got rdy=%b want 1", bus.in_ready);
        end
        tick();
        drive(7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'd1, 32'h1234_5678);
        n_tests++;
        if (bus.out_inst !== 32'h0020_A423 || inst_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL stall_second: got %h cnt=%0d want 0020a423 cnt=1", bus.out_inst, inst_cnt);
        end
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_inst !== 32'h0000_0013 || bus.out_err !== 1'b1 || inst_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL rsvd_word: got %h e=%b cnt=%0d want 00000013 e=1 cnt=2",
                     bus.out_inst, bus.out_err, inst_cnt);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({bus.out_valid, bus.out_err, bus.out_inst, inst_cnt, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL stall_reset: got v=%b e=%b i=%h cnt=%0d/%0d want all 0",
                     bus.out_valid, bus.out_err, bus.out_inst, inst_cnt, err_cnt);
        end
    endtask

    task automatic test_random();
        logic [32:0] q[$];
        logic [32:0] exp;
        logic [31:0] imm;
        int          fmt;
        int          m_inst = 0;
        int          m_err  = 0;
        bit          rdy_m;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            fmt = int'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2:       imm = 32'($urandom_range(0, 63));
                default: imm = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 1));
            endcase
            drive(fmt, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  3'($urandom), 7'($urandom), imm);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            rdy_m = (q.size() == 0) || bus.out_ready;
            n_tests++;
            if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== rdy_m) begin
                n_fail++;
                $display("FAIL rnd_hs[%0d]: got v=%b rdy=%b want v=%b rdy=%b",
                         c, bus.out_valid, bus.in_ready, q.size() != 0, rdy_m);
            end
            if (q.size() != 0) begin
                n_tests++;
                if ({bus.out_err, bus.out_inst} !== q[0]) begin
                    n_fail++;
                    $display("FAIL rnd_word[%0d]: got e=%b i=%h want e=%b i=%h",
                             c, bus.out_err, bus.out_inst, q[0][32], q[0][31:0]);
                end
            end
            n_tests++;
            if (inst_cnt !== 4'(m_inst) || err_cnt !== 4'(m_err)) begin
                n_fail++;
                $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", c, inst_cnt, err_cnt, m_inst, m_err);
            end
            if (q.size() != 0 && bus.out_ready) begin
                exp = q.pop_front();
                if (m_inst < CNT_MAX) m_inst++;
                if (exp[32] && m_err < CNT_MAX) m_err++;
            end
            if (bus.in_valid && rdy_m)
                q.push_back(model(fmt, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                                  bus.in_funct3, bus.in_funct7, imm));
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        test_reset();
        test_i_s();
        test_back_to_back();
        test_range();
        test_backpressure();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Instruction packer: accepts decoded RV32I fields plus a full 32-bit immediate and reassembles the 32-bit instruction word, scattering the immediate bits into the I/S/B/U/J/shift slots. It is the inverse of the core's immediate sign-extension stage. Sits in the trace/test infrastructure, feeding instruction-memory loaders and the decode-side checkers through a valid/ready stream with one output register stage. Also checks immediate representability and keeps accept and error counters.

## Interface
- CNT_W, 16, width of the saturating counters
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept this cycle
- in_fmt  in  3  format code (FMT_* in the shared package)
- in_opcode  in  7  opcode, placed at inst[6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7; used by R and SHIFT only
- in_imm  in  32  immediate as a sign-extended value
- out_valid  out  1  packed word valid
- out_ready  in  1  consumer accepts
- out_inst  out  32  packed instruction
- out_err  out  1  word is flagged invalid
- inst_cnt  out  CNT_W  words accepted at the output
- err_cnt  out  CNT_W  flagged words accepted at the output

## Operation
Format codes:
- FMT_R=0: funct7|rs2|rs1|f3|rd|op
- FMT_I=1: inst[31:20]=imm[11:0]
- FMT_S=2: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]
- FMT_B=3: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11]
- FMT_U=4: inst[31:12]=imm[31:12]
- FMT_J=5: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]
- FMT_SHIFT=6: inst[31:25]=funct7, inst[24:20]=imm[4:0]
- 7: reserved

Field usage:
- Fields not used by a format are ignored: rs2 for I/U/J/SHIFT, rs1/f3 for U/J, rd for S/B.
- Immediate bits not represented by a format are discarded.

Range rules (see Configuration):
- I/S: imm[31:11] all equal.
- B: imm[31:12] all equal and imm[0]=0.
- J: imm[31:20] all equal and imm[0]=0.
- U: imm[11:0]=0.
- SHIFT: imm[31:5]=0.
- R: never errs.

Reserved format:
- Always produces out_inst=0x00000013 (nop) and out_err=1, independent of the macro.

Counters:
- inst_cnt increments on each out_valid&&out_ready.
- err_cnt increments on each out_valid&&out_ready&&out_err.
- Both saturate at all-ones; they do not wrap.

## Timing
- in_ready = !out_valid || out_ready; combinational, with no dependency on in_valid.
- Input fire (in_valid&&in_ready): the packed word and error flag load into the output register. out_valid=1 on the next cycle, giving latency 1.
- Simultaneous output accept and input fire: the new word replaces the old one in the same edge, so full throughput is one word per cycle.
- Output accept with no input fire: out_valid clears.
- While out_valid&&!out_ready: out_inst and out_err hold stable and the input is stalled.
- Reset values: out_valid=0, out_inst=0, out_err=0, inst_cnt=0, err_cnt=0.
- Reset mid-stall discards the held word and leaves it uncounted.
- in_ready is 1 during the cycle following reset deassertion.

## Configuration
IMM_RANGE_CHECK_EN:
- Defined: range rules are evaluated and a violation sets out_err=1. The word is still packed from the truncated bits.
- Undefined: no range check. out_err is asserted only for the reserved format; otherwise it stays 0.

## Structure
- Shared package rv_imm_pkg holds:
  - FMT_* codes
  - opcode constants OP_IMM=0x13, OP_STORE=0x23, OP_BRANCH=0x63, OP_JAL=0x6F, OP_LUI=0x37
  - the nop word
- Sub-module imm_pack (combinational): fields plus imm in, packed word and range-error flag out.
- Top level holds the handshake, output register and counters.

## Test plan
- I: op 0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> out_inst=0xFFF00093, out_err=0, one cycle after fire.
- S: op 0x23, rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423.
- B then J back-to-back with out_ready=1:
  - B: op 0x63, rs1=rs2=0, imm=0xFFFFFFFC -> 0xFE000EE3.
  - J: op 0x6F, rd=1, imm=0x800 -> 0x001000EF.
  - inst_cnt=2.
- Range: FMT_I, rd=1, imm=2048:
  - With macro -> out_err=1, err_cnt=1.
  - Without macro -> 0x80000093, out_err=0.
- Backpressure: two inputs with out_ready=0 for 3 cycles -> first word held stable, in_ready=0, second accepted the cycle out_ready rises. Then fmt=7 -> 0x00000013 with out_err=1. Assert rst while stalled -> all outputs 0 on the next cycle.
